mdio_peripheral: RTL
====================

MDIO_PERIPHERAL -- requirements
Module: mdio_peripheral

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1, the PHY address this block answers to.
REQ-002 SHALL have port CLK, input, 1, system clock; the only clock in the block.
REQ-003 SHALL have port RESET, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port MDC, input, 1, MDIO clock from the MDIO controller; treated as data and sampled on CLK.
REQ-005 SHALL have port MDIO_OE, input, 1, controller output enable; 1 means the controller drives the bus.
REQ-006 SHALL have port MDIO_OUT, input, 1, controller serial data.
REQ-007 SHALL have port MDIO_IN, output, 1, serial data returned to the controller; 1 when idle (pull-up model).
REQ-008 SHALL have port REG_ADDR, output, 5, register address of the current frame.
REQ-009 SHALL have port REG_RDATA, input, 16, register-bank read data for REG_ADDR.
REQ-010 SHALL have port REG_WDATA, output, 16, write data from the frame.
REQ-011 SHALL have port REG_WE, output, 1, one-CLK write strobe.
REQ-012 SHALL have port BUSY, output, 1, high from the first ST bit until the frame ends or aborts.
REQ-013 SHALL have port FRAME_ERR, output, 1, one-CLK pulse on frame abort.

Function
REQ-014 SHALL register MDC once per CLK and detect rise = MDC & ~mdc_q and fall = ~MDC & mdc_q.
- Bus sampling occurs only on rise.
- MDIO_IN changes only on fall.
REQ-015 SHALL index MDC rises from the first ST bit as edge 0:
- ST: 0-1
- OP: 2-3
- PHYAD: 4-8
- REGAD: 9-13
- TA: 14-15
- DATA: 16-31
- All fields MSB first.
REQ-016 SHALL implement states IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, with a 5-bit edge counter.
REQ-017 IDLE SHALL move to ST on a rise with MDIO_OE=1 and MDIO_OUT=0; all other rises are ignored.
REQ-018 ST SHALL require MDIO_OUT=1 at edge 1; otherwise it SHALL return to IDLE and pulse FRAME_ERR.
REQ-019 OP SHALL decode the two OP bits:
- 10 = read
- 01 = write
- 00 or 11 = abort with FRAME_ERR.
REQ-020 If PHYAD != PHY_ADDR after edge 8, the block SHALL stay silent: no REG_WE, MDIO_IN stays 1, counting continues to edge 31, then IDLE, no FRAME_ERR.
REQ-021 REG_ADDR SHALL update on the CLK after edge 13 and hold until the next frame's edge 13.
REQ-022 Read frames: REG_RDATA SHALL be captured into a 16-bit shift register two CLKs after edge 13.
REQ-023 Read frames: MDIO_IN SHALL go to 0 at the fall after edge 14, and data bit 15-k SHALL be placed at the fall after edge 15+k (k = 0..15).
REQ-024 Read frames: MDIO_IN SHALL return to 1 at the fall after edge 31.
REQ-025 Write frames: TA SHALL be 1 at edge 14 and 0 at edge 15; otherwise abort with FRAME_ERR.
REQ-026 Write frames: REG_WDATA SHALL be valid when REG_WE pulses, one CLK after edge 31.
REQ-027 During ST..TA of a write, and WDATA, a rise with MDIO_OE=0 SHALL abort to IDLE with FRAME_ERR; MDIO_OE is ignored in RDATA.
REQ-028 BUSY SHALL drop in the same CLK that REG_WE pulses, that FRAME_ERR pulses, or that the read completes.
REQ-029 A new ST bit (0) on the rise immediately following edge 31 SHALL be accepted as the start of a back-to-back frame.
REQ-030 On a bare rise and fall of MDC in the same CLK window (no setup), only the registered MDC is used; no double counting.

Reset
REQ-031 RESET=0 SHALL asynchronously force:
- state=IDLE, counter=0
- MDIO_IN=1
- REG_ADDR=0, REG_WDATA=0
- REG_WE=0, BUSY=0, FRAME_ERR=0
- shift register=0, mdc_q=0
REQ-032 Reset asserted mid-frame SHALL discard the frame without a write strobe; after release, the block waits in IDLE for a new ST bit.

Structure
REQ-033 A shared package SHALL hold:
- state encoding
- OP codes (READ=2'b10, WRITE=2'b01)
- ST pattern 2'b01, TA-write pattern 2'b10
- field edge boundaries (1, 3, 8, 13, 15, 31)
REQ-034 Edge detection SHALL be one sub-module, mdc_edge_detect (outputs rise/fall); the register bank stays outside this block.

Verification
REQ-035 Write frame, PHYAD=1, REGAD=5'h04, data 16'hA5C3 -> one REG_WE pulse, REG_ADDR=5'h04, REG_WDATA=16'hA5C3, no FRAME_ERR.
REQ-036 Read frame, PHYAD=1, REGAD=5'h02, REG_RDATA=16'h1234 -> MDIO_IN reads 0 then 0001001000110100 on edges 16..31, then returns to 1.
REQ-037 Write frame, PHYAD=5'h07 -> no REG_WE, MDIO_IN stays 1, BUSY through edge 31, no FRAME_ERR.
REQ-038 OP=11, or write TA=00 -> FRAME_ERR pulse, BUSY low, next valid frame accepted.
REQ-039 RESET=0 at edge 20 of a write frame -> no REG_WE, all outputs at reset values immediately.
REQ-040 Two back-to-back writes (16'h0001 to reg 3, 16'hFFFF to reg 4) -> two REG_WE pulses with matching data and address.

Source files
------------

// File: rtl/mdio_peripheral_pkg.sv
// ============================================================================
// Module      : mdio_peripheral_pkg
// Description : Shared MDIO frame constants, state encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdio_peripheral_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST    = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_WDATA = 3'd6,
    S_RDATA = 3'd7
  } mdio_state_t;

  localparam logic [1:0] c_OP_READ    = 2'b10;
  localparam logic [1:0] c_OP_WRITE   = 2'b01;
  localparam logic [1:0] c_ST_PATTERN = 2'b01;
  localparam logic [1:0] c_TA_WRITE   = 2'b10;

  // Index of the last MDC rise belonging to each field
  localparam logic [4:0] c_EDGE_ST_END   = 5'd1;
  localparam logic [4:0] c_EDGE_OP_END   = 5'd3;
  localparam logic [4:0] c_EDGE_PHY_END  = 5'd8;
  localparam logic [4:0] c_EDGE_REG_END  = 5'd13;
  localparam logic [4:0] c_EDGE_TA_END   = 5'd15;
  localparam logic [4:0] c_EDGE_DATA_END = 5'd31;

  function automatic logic is_valid_op(input logic [1:0] op);
    return (op == c_OP_READ) || (op == c_OP_WRITE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdio_peripheral_mdc_edge_detect.sv
// ============================================================================
// Module      : mdc_edge_detect
// Description : Registers MDC on CLK and flags its rising and falling edges.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdc_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic MDC,
  output logic rise,
  output logic fall
);

  logic r_mdc_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_mdc_q <= 1'b0;
    end else begin
      r_mdc_q <= MDC;
    end
  end

  assign rise = MDC & ~r_mdc_q;
  assign fall = ~MDC & r_mdc_q;

endmodule

`default_nettype wire

// File: rtl/mdio_peripheral.sv
// ============================================================================
// Module      : mdio_peripheral
// Description : MDIO (clause 22) management-frame target with register port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdio_peripheral
  import mdio_peripheral_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDC,
  input  logic        MDIO_OE,
  input  logic        MDIO_OUT,
  output logic        MDIO_IN,
  output logic [4:0]  REG_ADDR,
  input  logic [15:0] REG_RDATA,
  output logic [15:0] REG_WDATA,
  output logic        REG_WE,
  output logic        BUSY,
  output logic        FRAME_ERR
);

  logic        w_rise;
  logic        w_fall;
  logic [15:0] w_bits;
  logic        w_oe_chk;
  logic        w_abort;

  mdio_state_t r_state;
  logic [4:0]  r_cnt;
  logic [14:0] r_in_sh;
  logic        r_is_read;
  logic        r_match;
  logic        r_rd_active;
  logic [4:0]  r_regad;
  logic        r_addr_pend;
  logic        r_cap_pend;
  logic [15:0] r_shift;

  mdc_edge_detect u_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .MDC   (MDC),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  // Most recent bits including the one being sampled on this rise
  assign w_bits = {r_in_sh, MDIO_OUT};

  always_comb begin
    w_oe_chk = 1'b0;
    case (r_state)
      S_ST, S_OP, S_PHYAD: w_oe_chk = 1'b1;
      S_REGAD:             w_oe_chk = r_match;
      S_TA, S_WDATA:       w_oe_chk = r_match & ~r_is_read;
      default:             w_oe_chk = 1'b0;
    endcase
  end

  assign w_abort = (w_oe_chk & ~MDIO_OE)
                 | ((r_state == S_ST) && (w_bits[1:0] != c_ST_PATTERN))
                 | ((r_state == S_OP) && (r_cnt == c_EDGE_OP_END) && !is_valid_op(w_bits[1:0]))
                 | ((r_state == S_TA) && (r_cnt == c_EDGE_TA_END) && r_match && !r_is_read
                    && (w_bits[1:0] != c_TA_WRITE));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_in_sh     <= 15'd0;
      r_is_read   <= 1'b0;
      r_match     <= 1'b0;
      r_rd_active <= 1'b0;
      r_regad     <= 5'd0;
      r_addr_pend <= 1'b0;
      r_cap_pend  <= 1'b0;
      r_shift     <= 16'd0;
      MDIO_IN     <= 1'b1;
      REG_ADDR    <= 5'd0;
      REG_WDATA   <= 16'd0;
      REG_WE      <= 1'b0;
      BUSY        <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      REG_WE      <= 1'b0;
      FRAME_ERR   <= 1'b0;
      r_addr_pend <= 1'b0;
      // Address goes out one CLK after edge 13, read data is taken one CLK later
      r_cap_pend  <= r_addr_pend & r_rd_active;
      if (r_addr_pend) REG_ADDR <= r_regad;
      if (r_cap_pend)  r_shift  <= REG_RDATA;

      if (w_rise) begin
        r_in_sh <= w_bits[14:0];
        if (r_state == S_IDLE) begin
          if (MDIO_OE && !MDIO_OUT) begin
            r_state <= S_ST;
            r_cnt   <= c_EDGE_ST_END;
            BUSY    <= 1'b1;
          end
        end else if (w_abort) begin
          r_state     <= S_IDLE;
          r_cnt       <= 5'd0;
          r_rd_active <= 1'b0;
          BUSY        <= 1'b0;
          FRAME_ERR   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 5'd1;
          case (r_state)
            S_ST: r_state <= S_OP;
            S_OP: if (r_cnt == c_EDGE_OP_END) begin
              r_state   <= S_PHYAD;
              r_is_read <= (w_bits[1:0] == c_OP_READ);
            end
            S_PHYAD: if (r_cnt == c_EDGE_PHY_END) begin
              r_state <= S_REGAD;
              r_match <= (w_bits[4:0] == PHY_ADDR);
            end
            S_REGAD: if (r_cnt == c_EDGE_REG_END) begin
              r_state     <= S_TA;
              r_regad     <= w_bits[4:0];
              r_addr_pend <= 1'b1;
              r_rd_active <= r_is_read & r_match;
            end
            S_TA: if (r_cnt == c_EDGE_TA_END) begin
              r_state <= r_is_read ? S_RDATA : S_WDATA;
            end
            S_WDATA: if (r_cnt == c_EDGE_DATA_END) begin
              r_state <= S_IDLE;
              BUSY    <= 1'b0;
              if (r_match) begin
                REG_WE    <= 1'b1;
                REG_WDATA <= w_bits;
              end
            end
            S_RDATA: if (r_cnt == c_EDGE_DATA_END) begin
              r_state     <= S_IDLE;
              r_rd_active <= 1'b0;
              BUSY        <= 1'b0;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end

      if (w_fall) begin
        if (r_rd_active && (r_state == S_TA) && (r_cnt == c_EDGE_TA_END)) begin
          MDIO_IN <= 1'b0;
        end else if (r_rd_active && (r_state == S_RDATA)) begin
          MDIO_IN <= r_shift[15];
          r_shift <= {r_shift[14:0], 1'b0};
        end else begin
          MDIO_IN <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
